// File: rtl/async_rr_arbiter.sv
// Round-robin pull scheduler: fetches one word at a time from num_src req/ack sources
// and hands it to a single downstream puller, skipping sources that stay silent too long.
module async_rr_arbiter #(
    parameter int unsigned num_src    = 4,
    parameter int unsigned data_width = 32,
    parameter int unsigned timeout    = 8,
    localparam int unsigned ID_W      = (num_src > 1) ? $clog2(num_src) : 1,
    localparam int unsigned CNT_W     = $clog2(timeout) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [num_src-1:0]            src_req,
    input  logic [num_src-1:0]            src_ack,
    input  logic [num_src*data_width-1:0] src_din,
    input  logic                          dst_req,
    output logic                          dst_ack,
    output logic [data_width-1:0]         dst_dout,
    output logic [ID_W-1:0]               dst_src_id,
    output logic [31:0]                   skip_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [num_src-1:0]     src_req_q, src_req_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [data_width-1:0]  data_q, data_d;
    logic                   dst_ack_q, dst_ack_d;
    logic [data_width-1:0]  dst_dout_q, dst_dout_d;
    logic [ID_W-1:0]        dst_src_id_q, dst_src_id_d;
    logic [31:0]            skip_count_q, skip_count_d;

    logic [data_width-1:0]  din_arr [num_src];
    logic [data_width-1:0]  sel_din;
    logic                   sel_ack;
    logic                   timed_out;
    logic [ID_W-1:0]        ptr_next;

    for (genvar i = 0; i < num_src; i++) begin : g_din
        assign din_arr[i] = src_din[data_width*i +: data_width];
    end

    // Only the currently selected source is ever listened to.
    assign sel_din   = din_arr[ptr_q];
    assign sel_ack   = src_ack[ptr_q];
    assign timed_out = (cnt_q == CNT_W'(timeout - 1));
    assign ptr_next  = (ptr_q == ID_W'(num_src - 1)) ? '0 : ptr_q + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dst_req) state_d = FETCH;
            FETCH: begin
                if (sel_ack)        state_d = HOLD;
                else if (timed_out) state_d = DRAIN;
            end
            DRAIN:   state_d = sel_ack ? HOLD : IDLE;
            HOLD:    if (dst_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_req_d    = src_req_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        data_d       = data_q;
        dst_ack_d    = 1'b0;
        dst_dout_d   = dst_dout_q;
        dst_src_id_d = dst_src_id_q;
        skip_count_d = skip_count_q;
        case (state_q)
            IDLE: begin
                if (dst_req) begin
                    src_req_d = num_src'(1) << ptr_q;
                    cnt_d     = '0;
                end else begin
                    src_req_d = '0;
                end
            end
            FETCH: begin
                if (sel_ack) begin
                    data_d    = sel_din;
                    src_req_d = '0;
                end else if (timed_out) begin
                    src_req_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // One grace cycle for a source that saw req just before it dropped.
            DRAIN: begin
                if (sel_ack) begin
                    data_d = sel_din;
                end else begin
                    ptr_d        = ptr_next;
                    skip_count_d = skip_count_q + 32'd1;
                end
            end
            HOLD: begin
                src_req_d = '0;
                if (dst_req) begin
                    dst_ack_d    = 1'b1;
                    dst_dout_d   = data_q;
                    dst_src_id_d = ptr_q;
                    ptr_d        = ptr_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_req_q    <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            data_q       <= '0;
            dst_ack_q    <= 1'b0;
            dst_dout_q   <= '0;
            dst_src_id_q <= '0;
            skip_count_q <= '0;
        end else begin
            src_req_q    <= src_req_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            data_q       <= data_d;
            dst_ack_q    <= dst_ack_d;
            dst_dout_q   <= dst_dout_d;
            dst_src_id_q <= dst_src_id_d;
            skip_count_q <= skip_count_d;
        end
    end

    assign src_req    = src_req_q;
    assign dst_ack    = dst_ack_q;
    assign dst_dout   = dst_dout_q;
    assign dst_src_id = dst_src_id_q;
    assign skip_count = skip_count_q;

endmodule

// File: tb/tb_async_rr_arbiter.sv
// Self-checking bench for async_rr_arbiter: table of expected deliveries plus
// hand-written sequences for hold, reset, late-ack and stray-ack corner cases.
module tb_async_rr_arbiter;

    localparam int unsigned NS  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 8;
    localparam int unsigned IDW = 2;

    localparam logic [1:0] M_NORMAL = 2'd0;
    localparam logic [1:0] M_NEVER  = 2'd1;
    localparam logic [1:0] M_LATE   = 2'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_req;
    logic [NS-1:0]     src_ack;
    logic [NS*DW-1:0]  src_din;
    logic              dst_req;
    logic              dst_ack;
    logic [DW-1:0]     dst_dout;
    logic [IDW-1:0]    dst_src_id;
    logic [31:0]       skip_count;

    async_rr_arbiter #(.num_src(NS), .data_width(DW), .timeout(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_req    (src_req),
        .src_ack    (src_ack),
        .src_din    (src_din),
        .dst_req    (dst_req),
        .dst_ack    (dst_ack),
        .dst_dout   (dst_dout),
        .dst_src_id (dst_src_id),
        .skip_count (skip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          seg;
        logic [31:0] exp_dout;
        logic [31:0] exp_id;
        int          exp_gap;
        logic [31:0] exp_skip;
    } vec_t;

    vec_t        vecs[$];
    logic [1:0]  mode [NS];
    logic [31:0] val  [NS];
    logic [NS-1:0] req_prev;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          last_ack_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Advance to the next falling edge and let every source model react.
    task automatic tick();
        logic a;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NS; i++) begin
            case (mode[i])
                M_NORMAL: a = src_req[i] && req_prev[i] && !src_ack[i];
                M_LATE:   a = req_prev[i] && !src_req[i];
                default:  a = 1'b0;
            endcase
            if (a) begin
                src_din[i*DW +: DW] = val[i];
                val[i] = val[i] + 32'd1;
            end
            src_ack[i]  = a;
            req_prev[i] = src_req[i];
        end
    endtask

    task automatic wait_ack(input string name, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (dst_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL %s: dst_ack not seen within 200 cycles, expected a delivery", name);
        end
    endtask

    task automatic wait_req(input string name, input int idx, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (src_req[idx] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL %s: src_req[%0d] not seen within 200 cycles", name, idx);
        end
    endtask

    task automatic reset_env(input int seg);
        rst      = 1'b1;
        dst_req  = 1'b0;
        src_ack  = '0;
        src_din  = '0;
        req_prev = '0;
        for (int i = 0; i < NS; i++) begin
            mode[i] = M_NORMAL;
            val[i]  = 32'(i * 100);
        end
        case (seg)
            1:       mode[1] = M_NEVER;
            2:       mode[2] = M_LATE;
            3:       mode[3] = M_NEVER;
            default: ;
        endcase
        tick();
        tick();
        rst     = 1'b0;
        dst_req = 1'b1;
        last_ack_cyc = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int cur_seg;
        int gap;
        int hi;
        bit held_ok;

        // seg 0: all sources ack promptly; seg 1: source 1 silent; seg 2: source 2 acks in DRAIN
        vecs.push_back('{0, 32'd0,   32'd0, 0,  32'd0});
        vecs.push_back('{0, 32'd100, 32'd1, 4,  32'd0});
        vecs.push_back('{0, 32'd200, 32'd2, 4,  32'd0});
        vecs.push_back('{0, 32'd300, 32'd3, 4,  32'd0});
        vecs.push_back('{0, 32'd1,   32'd0, 4,  32'd0});
        vecs.push_back('{0, 32'd101, 32'd1, 4,  32'd0});
        vecs.push_back('{0, 32'd201, 32'd2, 4,  32'd0});
        vecs.push_back('{0, 32'd301, 32'd3, 4,  32'd0});
        vecs.push_back('{1, 32'd0,   32'd0, 0,  32'd0});
        vecs.push_back('{1, 32'd200, 32'd2, 14, 32'd1});
        vecs.push_back('{1, 32'd300, 32'd3, 4,  32'd1});
        vecs.push_back('{1, 32'd1,   32'd0, 4,  32'd1});
        vecs.push_back('{1, 32'd201, 32'd2, 14, 32'd2});
        vecs.push_back('{2, 32'd0,   32'd0, 0,  32'd0});
        vecs.push_back('{2, 32'd100, 32'd1, 4,  32'd0});
        vecs.push_back('{2, 32'd200, 32'd2, 11, 32'd0});
        vecs.push_back('{2, 32'd300, 32'd3, 4,  32'd0});

        reset_env(0);
        rst     = 1'b1;
        dst_req = 1'b0;
        tick();
        chk("reset_src_req",    32'(src_req),    32'd0);
        chk("reset_dst_ack",    32'(dst_ack),    32'd0);
        chk("reset_dst_dout",   dst_dout,        32'd0);
        chk("reset_dst_src_id", 32'(dst_src_id), 32'd0);
        chk("reset_skip_count", skip_count,      32'd0);

        cur_seg = -1;
        foreach (vecs[v]) begin
            if (vecs[v].seg != cur_seg) begin
                cur_seg = vecs[v].seg;
                reset_env(cur_seg);
            end
            wait_ack($sformatf("vec%0d_ack", v), ok);
            if (ok) begin
                gap = cyc - last_ack_cyc;
                last_ack_cyc = cyc;
                chk($sformatf("vec%0d_dout", v), dst_dout, vecs[v].exp_dout);
                chk($sformatf("vec%0d_id", v),   32'(dst_src_id), vecs[v].exp_id);
                chk($sformatf("vec%0d_skip", v), skip_count, vecs[v].exp_skip);
                if (vecs[v].exp_gap != 0)
                    chk($sformatf("vec%0d_gap", v), 32'(gap), 32'(vecs[v].exp_gap));
            end
        end

        // Silent source 1: request stays up exactly timeout cycles, skip lands after DRAIN.
        reset_env(1);
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (src_req[1] === 1'b1) hi++;
            else if (hi > 0) break;
        end
        chk("t2_req1_high_cycles", 32'(hi), 32'(TO));
        chk("t2_skip_in_drain", skip_count, 32'd0);
        tick();
        chk("t2_skip_after_drain", skip_count, 32'd1);

        // Downstream stalls while a word from source 1 is held.
        reset_env(0);
        wait_ack("t4_first_ack", ok);
        wait_req("t4_req1", 1, ok);
        dst_req = 1'b0;
        tick();
        tick();
        held_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dst_ack !== 1'b0 || src_req !== '0 || dst_dout !== 32'd0) held_ok = 1'b0;
        end
        chk("t4_quiet_while_held", 32'(held_ok), 32'd1);
        dst_req = 1'b1;
        tick();
        chk("t4_ack_after_req", 32'(dst_ack), 32'd1);
        chk("t4_held_dout",     dst_dout,     32'd100);
        chk("t4_held_id",       32'(dst_src_id), 32'd1);
        tick();
        chk("t4_ack_pulse_len", 32'(dst_ack), 32'd0);

        // Reset in the middle of a fetch from source 3.
        reset_env(3);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (skip_count === 32'd1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_first_skip_seen", 32'(ok), 32'd1);
        wait_req("t5_req3", 3, ok);
        tick();
        tick();
        tick();
        chk("t5_still_fetching", 32'(src_req), 32'b1000);
        rst = 1'b1;
        tick();
        chk("t5_rst_src_req", 32'(src_req), 32'd0);
        chk("t5_rst_skip",    skip_count,   32'd0);
        chk("t5_rst_dst_ack", 32'(dst_ack), 32'd0);
        rst     = 1'b0;
        mode[3] = M_NORMAL;
        wait_ack("t5_post_reset_ack", ok);
        if (ok) begin
            chk("t5_post_reset_id",   32'(dst_src_id), 32'd0);
            chk("t5_post_reset_dout", dst_dout,        32'd2);
        end

        // Stray ack from source 0 while source 2 is being fetched.
        reset_env(0);
        wait_ack("t6_ack0", ok);
        wait_ack("t6_ack1", ok);
        wait_req("t6_req2", 2, ok);
        src_ack[0]       = 1'b1;
        src_din[0 +: DW] = 32'hdead_beef;
        wait_ack("t6_ack2", ok);
        if (ok) begin
            chk("t6_id",   32'(dst_src_id), 32'd2);
            chk("t6_dout", dst_dout,        32'd200);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
